non_ov_n: RTL and testbench

- Parametrised successor to the two-phase non-overlap generator.
- Produces PHASES mutually exclusive, one-hot phase outputs from a single reference input, with a programmable all-low dead time between consecutive phases.
- Each ref transition (rising or falling) advances the active phase modulo PHASES. With PHASES=2, this gives the classic ph1/ph2 pair with a guaranteed gap.
- Sits between a slow reference (comparator, timer, pin) and switched-capacitor or bridge drivers on the clk domain.

---
 rtl/non_ov_n.sv | 183 ++++++++++++++++++
 tb/tb_non_ov_n.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/non_ov_n.sv
// non_ov_n: PHASES-way non-overlapping one-hot phase generator.
//
// Every transition (rise or fall) of the synchronised reference advances the
// active phase modulo PHASES. Between two phases all outputs are held low for
// exactly DEAD clk cycles. A new edge arriving during the gap restarts it.
//
// Ports:
//   clk     system clock, all logic on posedge
//   reset   synchronous, active-high reset
//   ref_in  reference input, asynchronous to clk (named ref_in because "ref"
//           is a SystemVerilog keyword)
//   en      level-sensitive enable; low forces IDLE and holds idx
//   ph      registered one-hot phase outputs (at most one bit high)
//   dead    registered, high while in the dead-time state
//   idx     registered index of the current or next phase, zero-extended
//   drop    (NON_OV_N_MIN_ON_EN only) sticky flag: an edge was discarded
//
// Optional feature, macro NON_OV_N_MIN_ON_EN: every phase stays high for at
// least MIN_ON cycles. One edge arriving early is held pending and acted on
// when the minimum on-time expires; further early edges are discarded and
// set drop.
module non_ov_n #(
    parameter int unsigned PHASES      = 2,
    parameter int unsigned DEAD        = 2,
    parameter int unsigned SYNC_STAGES = 2
`ifdef NON_OV_N_MIN_ON_EN
    ,
    parameter int unsigned MIN_ON      = 4
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ref_in,
    input  logic              en,
    output logic [PHASES-1:0] ph,
    output logic              dead,
    output logic [2:0]        idx
`ifdef NON_OV_N_MIN_ON_EN
    ,
    output logic              drop
`endif
);

    typedef enum logic [1:0] {StIdle, StDead, StOn} state_e;

    localparam logic [2:0]        IdxLast = 3'(PHASES - 1);
    localparam logic [3:0]        CntLoad = 4'(DEAD - 1);
    localparam logic [PHASES-1:0] PhOne   = {{(PHASES - 1){1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    ref_d_q;
    logic                    ref_s;
    logic                    edge_det;
    logic [3:0]              cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d, idx_nxt;
    logic [PHASES-1:0]       ph_q, ph_d;
    logic                    dead_q, dead_d;

`ifdef NON_OV_N_MIN_ON_EN
    localparam logic [5:0] OnLoad = 6'(MIN_ON - 1);

    logic [5:0] on_cnt_q, on_cnt_d;
    logic       pend_q, pend_d;
    logic       drop_q, drop_d;
`endif

    assign ref_s    = sync_q[SYNC_STAGES-1];
    assign edge_det = ref_s ^ ref_d_q;
    assign idx_nxt  = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef NON_OV_N_MIN_ON_EN
        on_cnt_d = on_cnt_q;
        pend_d   = pend_q;
        drop_d   = drop_q;
`endif
        if (!en) begin
            // idx is held so re-enabling resumes at the following phase
            state_d = StIdle;
`ifdef NON_OV_N_MIN_ON_EN
            pend_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (edge_det) begin
                        idx_d   = idx_nxt;
                        cnt_d   = CntLoad;
                        state_d = StDead;
                    end
                end
                StDead: begin
                    if (edge_det) begin
                        // a fresh edge always restarts the full gap
                        idx_d = idx_nxt;
                        cnt_d = CntLoad;
                    end else if (cnt_q == 4'd0) begin
                        state_d = StOn;
`ifdef NON_OV_N_MIN_ON_EN
                        on_cnt_d = OnLoad;
`endif
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StOn: begin
`ifdef NON_OV_N_MIN_ON_EN
                    if (on_cnt_q != 6'd0) begin
                        on_cnt_d = on_cnt_q - 6'd1;
                        if (edge_det) begin
                            if (pend_q) drop_d = 1'b1;
                            else        pend_d = 1'b1;
                        end
                    end else if (edge_det || pend_q) begin
                        // an edge on top of a pending one is the surplus one
                        if (edge_det && pend_q) drop_d = 1'b1;
                        pend_d  = 1'b0;
                        idx_d   = idx_nxt;
                        cnt_d   = CntLoad;
                        state_d = StDead;
                    end
`else
                    if (edge_det) begin
                        idx_d   = idx_nxt;
                        cnt_d   = CntLoad;
                        state_d = StDead;
                    end
`endif
                end
                default: state_d = StIdle;
            endcase
        end

        // outputs are registered from the next state so ph drops on the edge
        ph_d   = (state_d == StOn) ? (PhOne << idx_d) : '0;
        dead_d = (state_d == StDead);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            ref_d_q  <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            idx_q    <= IdxLast;
            ph_q     <= '0;
            dead_q   <= 1'b0;
`ifdef NON_OV_N_MIN_ON_EN
            on_cnt_q <= 6'd0;
            pend_q   <= 1'b0;
            drop_q   <= 1'b0;
`endif
        end else begin
            sync_q[0] <= ref_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            ref_d_q  <= ref_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ph_q     <= ph_d;
            dead_q   <= dead_d;
`ifdef NON_OV_N_MIN_ON_EN
            on_cnt_q <= on_cnt_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
`endif
        end
    end

    assign ph   = ph_q;
    assign dead = dead_q;
    assign idx  = idx_q;
`ifdef NON_OV_N_MIN_ON_EN
    assign drop = drop_q;
`endif

endmodule

// File: tb/tb_non_ov_n.sv
// Self-checking bench for non_ov_n (PHASES=3, DEAD=2, SYNC_STAGES=2).
// Each driven reference edge pushes its predicted phase and rise time to a
// scoreboard queue; the entry is popped when the DUT raises a phase.
module tb_non_ov_n;

    localparam int unsigned PHASES = 3;
    localparam int unsigned DEAD   = 2;
    localparam int unsigned SS     = 2;
`ifdef NON_OV_N_MIN_ON_EN
    localparam int unsigned MIN_ON = 5;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ref_in;
    logic              en;
    logic [PHASES-1:0] ph;
    logic              dead;
    logic [2:0]        idx;
`ifdef NON_OV_N_MIN_ON_EN
    logic              drop;
`endif

    non_ov_n #(
        .PHASES(PHASES),
        .DEAD(DEAD),
        .SYNC_STAGES(SS)
`ifdef NON_OV_N_MIN_ON_EN
        ,
        .MIN_ON(MIN_ON)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .ref_in(ref_in),
        .en(en),
        .ph(ph),
        .dead(dead),
        .idx(idx)
`ifdef NON_OV_N_MIN_ON_EN
        ,
        .drop(drop)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int model_idx;

    typedef struct {
        int t_rise;
        int idx;
    } exp_t;
    exp_t sb[$];

    // Invariant monitor: one-hot outputs and at least DEAD low cycles between
    // two different phases.
    logic [PHASES-1:0] last_ph = '0;
    int                low_run = 0;
    int                viol    = 0;
    always @(negedge clk) begin
        if (reset) begin
            last_ph <= '0;
            low_run <= 0;
        end else begin
            if ($countones(ph) > 1) viol <= viol + 1;
            if (ph == '0) begin
                low_run <= low_run + 1;
            end else begin
                if (last_ph != '0 && ph != last_ph && low_run < int'(DEAD)) viol <= viol + 1;
                last_ph <= ph;
                low_run <= 0;
            end
        end
    end

    function automatic logic [PHASES-1:0] onehot(input int i);
        logic [PHASES-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        ref_in = 1'b0;
        en     = 1'b1;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        model_idx = PHASES - 1;
        sb.delete();
    endtask

    // Called at a negedge; k is the edge at which the first sync flop captures.
    task automatic toggle(output int k);
        ref_in    = ~ref_in;
        k         = cyc + 1;
        model_idx = (model_idx + 1) % int'(PHASES);
    endtask

    // Waits (bounded) for dead to rise, then for a phase to rise after it.
    task automatic observe(output int t_dead, output int t_rise);
        t_dead = -1;
        t_rise = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (t_dead < 0 && dead === 1'b1) t_dead = cyc;
            if (t_dead >= 0 && ph !== '0) begin
                t_rise = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [PHASES+3:0] got, want;
        do_reset();
        want = {{PHASES{1'b0}}, 1'b0, 3'(PHASES - 1)};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            got = {ph, dead, idx};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%h want=%h", n, got, want);
            end
        end
    endtask

    task automatic test_sequence();
        int   k, td, tr;
        exp_t e;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            toggle(k);
            sb.push_back('{k + int'(SS + DEAD), model_idx});
            observe(td, tr);
            e = sb.pop_front();
            checks++;
            if (td !== k + int'(SS)) begin
                failures++;
                $display("FAIL seq_dead_start edge=%0d got=%0d want=%0d", n, td, k + int'(SS));
            end
            checks++;
            if (tr !== e.t_rise) begin
                failures++;
                $display("FAIL seq_rise_time edge=%0d got=%0d want=%0d", n, tr, e.t_rise);
            end
            checks++;
            if (ph !== onehot(e.idx)) begin
                failures++;
                $display("FAIL seq_ph edge=%0d got=%b want=%b", n, ph, onehot(e.idx));
            end
            checks++;
            if (idx !== 3'(e.idx)) begin
                failures++;
                $display("FAIL seq_idx edge=%0d got=%0d want=%0d", n, idx, e.idx);
            end
            while (cyc < k + 9) @(negedge clk);
            checks++;
            if (ph !== onehot(e.idx) || dead !== 1'b0) begin
                failures++;
                $display("FAIL seq_hold edge=%0d got=%b want=%b", n, ph, onehot(e.idx));
            end
        end
    endtask

    task automatic test_back_to_back();
        int   k, k1, k2, td, tr;
        exp_t e;
        do_reset();
        toggle(k);
        sb.push_back('{k + int'(SS + DEAD), model_idx});
        observe(td, tr);
        e = sb.pop_front();
        repeat (10) @(negedge clk);
        toggle(k1);
        @(negedge clk);
        toggle(k2);
        sb.push_back('{k2 + int'(SS + DEAD), model_idx});
        observe(td, tr);
        e = sb.pop_front();
        checks++;
        if (td !== k1 + int'(SS)) begin
            failures++;
            $display("FAIL b2b_dead_start got=%0d want=%0d", td, k1 + int'(SS));
        end
        checks++;
        if (tr !== e.t_rise) begin
            failures++;
            $display("FAIL b2b_rise_time got=%0d want=%0d", tr, e.t_rise);
        end
        checks++;
        if (ph !== onehot(e.idx) || idx !== 3'(e.idx)) begin
            failures++;
            $display("FAIL b2b_phase got=%b/%0d want=%b/%0d", ph, idx, onehot(e.idx), e.idx);
        end
    endtask

    task automatic test_enable();
        int   k, td, tr;
        exp_t e;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            toggle(k);
            sb.push_back('{k + int'(SS + DEAD), model_idx});
            observe(td, tr);
            e = sb.pop_front();
            repeat (6) @(negedge clk);
        end
        checks++;
        if (ph !== onehot(1) || idx !== 3'd1) begin
            failures++;
            $display("FAIL en_setup got=%b/%0d want=%b/1", ph, idx, onehot(1));
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (ph !== '0 || dead !== 1'b0 || idx !== 3'd1) begin
            failures++;
            $display("FAIL en_off got=%b/%b/%0d want=0/0/1", ph, dead, idx);
        end
        ref_in = ~ref_in;  // must be ignored while disabled
        repeat (8) @(negedge clk);
        checks++;
        if (ph !== '0 || idx !== 3'd1) begin
            failures++;
            $display("FAIL en_ignore got=%b/%0d want=0/1", ph, idx);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);
        toggle(k);
        sb.push_back('{k + int'(SS + DEAD), model_idx});
        observe(td, tr);
        e = sb.pop_front();
        checks++;
        if (tr !== e.t_rise) begin
            failures++;
            $display("FAIL en_resume_time got=%0d want=%0d", tr, e.t_rise);
        end
        checks++;
        if (ph !== onehot(2) || idx !== 3'd2 || e.idx != 2) begin
            failures++;
            $display("FAIL en_resume_phase got=%b/%0d want=%b/2", ph, idx, onehot(2));
        end
        // reset in the middle of a dead gap
        repeat (6) @(negedge clk);
        toggle(k);
        for (int n = 0; n < 10 && dead !== 1'b1; n++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ph !== '0 || dead !== 1'b0 || idx !== 3'(PHASES - 1)) begin
            failures++;
            $display("FAIL reset_mid_dead got=%b/%b/%0d want=0/0/%0d", ph, dead, idx, PHASES - 1);
        end
        ref_in = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        model_idx = PHASES - 1;
        toggle(k);
        sb.push_back('{k + int'(SS + DEAD), model_idx});
        observe(td, tr);
        e = sb.pop_front();
        checks++;
        if (tr !== e.t_rise || ph !== onehot(0) || idx !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_first got=%0d/%b/%0d want=%0d/%b/0",
                     tr, ph, idx, e.t_rise, onehot(0));
        end
    endtask

`ifdef NON_OV_N_MIN_ON_EN
    task automatic test_min_on();
        int   k, td, tr, tr0;
        exp_t e;
        do_reset();
        toggle(k);
        sb.push_back('{k + int'(SS + DEAD), model_idx});
        observe(td, tr0);
        e = sb.pop_front();
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL min_on_drop_clear got=%b want=0", drop);
        end
        toggle(k);         // early edge, becomes pending
        @(negedge clk);
        ref_in = ~ref_in;  // surplus edge, discarded
        sb.push_back('{tr0 + int'(MIN_ON + DEAD), model_idx});
        observe(td, tr);
        e = sb.pop_front();
        checks++;
        if (td !== tr0 + int'(MIN_ON)) begin
            failures++;
            $display("FAIL min_on_hold got=%0d want=%0d", td, tr0 + int'(MIN_ON));
        end
        checks++;
        if (tr !== e.t_rise || idx !== 3'(e.idx)) begin
            failures++;
            $display("FAIL min_on_next got=%0d/%0d want=%0d/%0d", tr, idx, e.t_rise, e.idx);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (drop !== 1'b1) begin
            failures++;
            $display("FAIL min_on_drop_set got=%b want=1", drop);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL min_on_drop_reset got=%b want=0", drop);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        ref_in = 1'b0;
        en     = 1'b0;
        model_idx = PHASES - 1;
        test_reset();
        test_sequence();
        test_back_to_back();
        test_enable();
`ifdef NON_OV_N_MIN_ON_EN
        test_min_on();
`endif
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL invariants got=%0d want=0", viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
